shift_serializer: RTL
=====================

# shift_serializer

Parallel-to-serial stage that accepts a word over a valid/ready handshake, loads it into an internal shift register and emits it one bit per accepted beat on a serial valid/ready port. It is the sequencing stage for the universal shift register datapath: it drives the load, shift and hold operations and consumes the parallel word supplied by the producing stage. Downstream back-pressure stalls shifting without losing bits.

## Interface
- N, 8, data word width in bits; N >= 2
- MSB_FIRST, 0, 0 = LSB transmitted first (right shift); 1 = MSB first (left shift)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  N  parallel word
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out valid
- ser_ready  input  1  downstream accepts ser_out this cycle
- frame_done  output  1  one-cycle pulse after the last bit of a frame is accepted
- busy  output  1  frame in progress (state != IDLE)

## Operation
- States: IDLE, SHIFT, and PAR (PAR exists only with SER_PARITY_EN).
- in_ready = (state == IDLE) && !rst.
- IDLE: when in_valid && in_ready, load in_data into sreg, clear bit counter cnt, go to SHIFT. Without in_valid, hold (fn = hold).
- SHIFT: ser_valid = 1. ser_out = sreg[0] when MSB_FIRST = 0, sreg[N-1] when MSB_FIRST = 1.
- SHIFT beat: on ser_valid && ser_ready, shift sreg one position toward the output end, fill the vacated bit with 0, and increment cnt.
- SHIFT stall: with ser_ready low, sreg, cnt and ser_out hold.
- Last data beat (cnt == N-1 and a beat occurs): go to PAR if parity is compiled in; otherwise go to IDLE and register frame_done = 1 for the next cycle.
- PAR: ser_valid = 1, ser_out = stored parity bit. On ser_ready, go to IDLE and pulse frame_done.
- cnt width is $clog2(N). cnt never exceeds N-1.
- ser_out = 0 whenever ser_valid = 0.
- in_data is sampled only on the accepting edge. Later changes to it have no effect.

## Timing
- Reset values: ser_out 0, ser_valid 0, frame_done 0, busy 0, in_ready 0 while rst is high and 1 in the first cycle after. Internally sreg = 0, cnt = 0, state = IDLE.
- Latency: the first serial bit is valid in the cycle after acceptance.
- Throughput with ser_ready tied high:
  - without parity, one frame per N+1 cycles (N bits plus one IDLE cycle);
  - with parity, one frame per N+2 cycles.
- frame_done is asserted in the IDLE cycle that follows the final accepted beat. That cycle may also accept the next word: the acceptance and the frame_done pulse occur together.
- rst mid-frame aborts immediately. The next cycle is IDLE with all outputs at reset values and no frame_done pulse.
- ser_valid never deasserts mid-frame without a completed beat. It is stable under stall, as the valid/ready rule requires.

## Configuration
- SER_PARITY_EN defined:
  - even parity (XOR of all N bits of in_data) is captured at load;
  - parity is sent as bit N+1 in state PAR;
  - frame length is N+1 beats.
- SER_PARITY_EN undefined:
  - the PAR state and the parity register are absent;
  - frame length is N beats.

## Structure
- Package shift_serializer_pkg contains:
  - state enum: IDLE, SHIFT, PAR;
  - shift-function constants: FN_HOLD = 2'b00, FN_LS = 2'b01, FN_RS = 2'b10, FN_LOAD = 2'b11. These match the universal shift register encoding so the FSM can later drive that register directly.
- One sub-module, ser_bit_counter: a parameterised up-counter with synchronous clear, enable and a terminal-count flag (cnt == N-1). The FSM, sreg and parity logic stay in the top level.

## Test plan
- Reset then idle: rst high for 2 cycles → in_ready = 0 during reset, then 1; ser_valid = 0, ser_out = 0, frame_done = 0.
- N=8, LSB first, ser_ready = 1, word 0xA5 → ser_out bits 1,0,1,0,0,1,0,1 on consecutive cycles; frame_done pulses one cycle after the 8th bit; busy is high for exactly 8 cycles.
- MSB_FIRST = 1, word 0x81, ser_ready low for 3 cycles after bit 2 → bit sequence 1,0,0,0,0,0,0,1 is unbroken; ser_out holds its value during the stall; total frame is 11 cycles.
- SER_PARITY_EN, word 0x07 → 8 data bits followed by parity bit 1. Word 0x03 → parity bit 0.
- Back-to-back words 0x0F, 0xF0 with in_valid held high → the second word is accepted in the frame_done cycle; 18 cycles from first acceptance to second frame_done.
- rst asserted at bit 4 of 0xFF → next cycle: ser_valid = 0, busy = 0, no frame_done. A following word 0x01 serialises correctly.

Source files
------------

// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the shift_serializer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The shift-function encoding matches the universal shift register, so the
// serializer FSM can drive that register's function select directly.
package shift_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam logic [1:0] FN_HOLD = 2'b00;
    localparam logic [1:0] FN_LS   = 2'b01;
    localparam logic [1:0] FN_RS   = 2'b10;
    localparam logic [1:0] FN_LOAD = 2'b11;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: counts accepted data beats.
// Latency: count updates on the edge after en; tc is combinational from count.
// Backpressure: none; en is only raised on an accepted beat.
//
// Ports: clk, rst (sync, active-high), clr (sync clear), en (count up),
//        tc (count == N-1). The count wraps to 0 after N-1 so it never
//        exceeds N-1, even for widths that are not a power of two.
module ser_bit_counter #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial stage: accepts an N-bit word, emits it one bit per beat.
// Latency: first serial bit valid the cycle after acceptance; frame_done one cycle after last beat.
// Backpressure: ser_ready low stalls shifting with ser_valid/ser_out held; in_ready only in IDLE.
//
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready parallel input;
//        ser_out/ser_valid/ser_ready serial output; frame_done pulse; busy.
// Option: define SER_PARITY_EN to append an even-parity bit (XOR of the word)
//         after the data bits, making each frame N+1 beats long.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         frame_done,
    output logic         busy
);
    // Direction of travel toward the output end of the register.
    localparam logic [1:0] FN_SHIFT = (MSB_FIRST != 0) ? FN_LS : FN_RS;

    state_t       state, state_nxt;
    logic [1:0]   fn;
    logic [N-1:0] sreg;
    logic         fd_nxt;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;
`ifdef SER_PARITY_EN
    logic         par_q;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    ser_bit_counter #(
        .N (N)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fn        = FN_HOLD;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        fd_nxt    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    fn        = FN_LOAD;
                    cnt_clr   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = (MSB_FIRST != 0) ? sreg[N-1] : sreg[0];
                if (ser_ready) begin
                    fn     = FN_SHIFT;
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
`ifdef SER_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = IDLE;
                        fd_nxt    = 1'b1;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
                if (ser_ready) begin
                    state_nxt = IDLE;
                    fd_nxt    = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: the shift register follows the function select, vacated bit is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fd_nxt;
            case (fn)
                FN_LOAD: sreg <= in_data;
                FN_RS:   sreg <= {1'b0, sreg[N-1:1]};
                FN_LS:   sreg <= {sreg[N-2:0], 1'b0};
                default: sreg <= sreg;
            endcase
        end
    end

`ifdef SER_PARITY_EN
    // Even parity of the whole word, captured alongside the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (fn == FN_LOAD) begin
            par_q <= ^in_data;
        end
    end
`endif

endmodule
